// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame shifted on device clock falls, ACK sample.
// Line drive updates 2 sync + FILTER_LEN + 1 cycles after a pad clock fall; tx_ready is high only in IDLE, requests while busy are dropped.
`timescale 1ns/1ps
module ps2_host_tx #(
   parameter int CLK_FREQ_HZ      = 50000000,
   parameter int INHIBIT_US       = 120,
   parameter int START_TIMEOUT_US = 15000,
   parameter int XFER_TIMEOUT_US  = 2000,
   parameter int FILTER_LEN       = 4
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic [1:0] tx_status,
   output logic       busy,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int CYC_PER_US  = CLK_FREQ_HZ / 1000000;
   localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
   localparam int START_CYC   = CYC_PER_US * START_TIMEOUT_US;
   localparam int XFER_CYC    = CYC_PER_US * XFER_TIMEOUT_US;
   localparam int TMR_MAX     = (INHIBIT_CYC > START_CYC) ?
                                ((INHIBIT_CYC > XFER_CYC) ? INHIBIT_CYC : XFER_CYC) :
                                ((START_CYC > XFER_CYC) ? START_CYC : XFER_CYC);
   localparam int TMR_W       = $clog2(TMR_MAX + 1);
   localparam int FLT_W       = $clog2(FILTER_LEN + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE, S_FINISH
   } state_t;

   state_t           state, state_nxt;
   logic [1:0]       clk_sync, dat_sync;
   logic             clk_s, dat_s;
   logic             clk_filt, clk_filt_d;
   logic [FLT_W-1:0] flt_cnt;
   logic             fall_edge;
   logic [9:0]       frame;
   logic [3:0]       bitcnt;
   logic [TMR_W-1:0] tmr;
   logic             nack;
   logic [1:0]       fin_status;
   logic             inh_end, start_to, xfer_to;
   logic             clk_oe_nxt, dat_oe_nxt;

   // Idle bus level is high, so synchronizers and filter reset to 1.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         clk_sync   <= 2'b11;
         dat_sync   <= 2'b11;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
         flt_cnt    <= '0;
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clk_in};
         dat_sync   <= {dat_sync[0], ps2_dat_in};
         clk_filt_d <= clk_filt;
         if (clk_s == clk_filt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
            clk_filt <= clk_s;
            flt_cnt  <= '0;
         end else begin
            flt_cnt <= flt_cnt + FLT_W'(1);
         end
      end
   end

   assign clk_s     = clk_sync[1];
   assign dat_s     = dat_sync[1];
   assign fall_edge = clk_filt_d & ~clk_filt;

   assign inh_end  = (tmr >= TMR_W'(INHIBIT_CYC - 1));
   assign start_to = (tmr >= TMR_W'(START_CYC - 1));
   assign xfer_to  = (tmr >= TMR_W'(XFER_CYC - 1));

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Timeouts are tested before fall_edge so they win a same-cycle race.
   always_comb begin
      state_nxt  = state;
      fin_status = 2'b00;
      case (state)
         S_IDLE:      if (tx_valid) state_nxt = S_INHIBIT;
         S_INHIBIT:   if (inh_end) state_nxt = S_RTS;
         S_RTS: begin
            if (start_to) begin
               state_nxt  = S_FINISH;
               fin_status = 2'b10;
            end else if (fall_edge) begin
               state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (xfer_to) begin
               state_nxt  = S_FINISH;
               fin_status = 2'b11;
            end else if (fall_edge && bitcnt == 4'd9) begin
               state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            if (xfer_to) begin
               state_nxt  = S_FINISH;
               fin_status = 2'b11;
            end else if (fall_edge) begin
               state_nxt = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (xfer_to) begin
               state_nxt  = S_FINISH;
               fin_status = 2'b11;
            end else if (clk_filt && dat_s) begin
               state_nxt  = S_FINISH;
               fin_status = {1'b0, nack};
            end
         end
         S_FINISH:    state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      clk_oe_nxt = (state_nxt == S_INHIBIT);
      dat_oe_nxt = 1'b0;
      case (state_nxt)
         S_RTS:   dat_oe_nxt = 1'b1;
         S_SHIFT: dat_oe_nxt = fall_edge ? ~frame[bitcnt] : ps2_dat_oe;
         default: dat_oe_nxt = 1'b0;
      endcase
   end

   assign tx_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);
   assign tx_done  = (state == S_FINISH);

   // The timer restarts on entry to INHIBIT/RTS and on the first device edge, then runs through the transfer.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         frame      <= '0;
         bitcnt     <= '0;
         tmr        <= '0;
         nack       <= 1'b0;
         tx_status  <= 2'b00;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
      end else begin
         ps2_clk_oe <= clk_oe_nxt;
         ps2_dat_oe <= dat_oe_nxt;
         if (state == S_IDLE && tx_valid) begin
            frame  <= {1'b1, ~^tx_data, tx_data};
            bitcnt <= '0;
         end
         if ((state == S_RTS || state == S_SHIFT) && fall_edge && state_nxt != S_FINISH)
            bitcnt <= bitcnt + 4'd1;
         if (state == S_ACK && state_nxt == S_WAIT_IDLE)
            nack <= dat_s;
         if (state_nxt == S_FINISH)
            tx_status <= fin_status;
         if (state_nxt != state && (state_nxt == S_INHIBIT || state_nxt == S_RTS))
            tmr <= '0;
         else if (state == S_RTS && state_nxt == S_SHIFT)
            tmr <= TMR_W'(1);
         else if (state == S_IDLE || state == S_FINISH || state_nxt == S_FINISH)
            tmr <= '0;
         else
            tmr <= tmr + TMR_W'(1);
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on wired-AND lines, directed commands, and a done-triggered scoreboard.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int CLK_FREQ_HZ = 1000000;
   localparam int INHIBIT_US  = 120;
   localparam int START_US    = 50;
   localparam int XFER_US     = 200;
   localparam int FILTER_LEN  = 4;
   localparam int HALF        = 8;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, tx_done, busy;
   logic [1:0] tx_status;
   logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;

   ps2_host_tx #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ), .INHIBIT_US(INHIBIT_US),
      .START_TIMEOUT_US(START_US), .XFER_TIMEOUT_US(XFER_US), .FILTER_LEN(FILTER_LEN)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_done(tx_done), .tx_status(tx_status), .busy(busy),
      .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
   );

   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   always #5 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [1:0] status;
      bit         chk_data;
      logic [7:0] data;
      logic       par;
      int         done_cyc;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [9:0] dev_bits;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   always @(negedge CLOCK_50) begin
      if (!reset && tx_done === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: tx_done with status %0h, no command outstanding", tx_status);
         end else begin
            mon_e = sb.pop_front();
            check("status", int'(tx_status), int'(mon_e.status));
            check("clk_oe_at_done", int'(ps2_clk_oe), 0);
            check("dat_oe_at_done", int'(ps2_dat_oe), 0);
            if (mon_e.done_cyc != 0) check("done_cycle", cyc, mon_e.done_cyc);
            if (mon_e.chk_data) begin
               check("line_data", int'(dev_bits[7:0]), int'(mon_e.data));
               check("line_parity", int'(dev_bits[8]), int'(mon_e.par));
               check("line_stop", int'(dev_bits[9]), 1);
            end
         end
      end
   end

   task automatic send(input logic [7:0] d);
      int g = 0;
      @(negedge CLOCK_50);
      while (!tx_ready && g < 1000) begin
         @(negedge CLOCK_50);
         g++;
      end
      check("ready_before_send", int'(tx_ready), 1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge CLOCK_50);
      #1 tx_valid = 1'b0;
   endtask

   // Device side: waits for the host's inhibit/RTS, then generates n_edges clocks, reading each bit mid-high.
   task automatic dev_run(input int n_edges, input bit ack, input int glitch_at,
                          output int inh_cycles, output int rts_cyc, output int first_fall_cyc);
      int g = 0;
      inh_cycles     = 0;
      rts_cyc        = 0;
      first_fall_cyc = 0;
      while (g < 2000) begin
         @(negedge CLOCK_50);
         g++;
         if (ps2_clk_oe) inh_cycles++;
         else if (inh_cycles > 0) break;
      end
      if (g >= 2000) begin
         tests++;
         fails++;
         $display("FAIL rts_wait: no inhibit/RTS seen within %0d cycles", g);
         return;
      end
      rts_cyc = cyc;
      check("start_bit_dat_oe", int'(ps2_dat_oe), 1);
      tick(4);
      for (int k = 1; k <= n_edges; k++) begin
         if (k == 11) dev_dat = ~ack;
         dev_clk = 1'b0;
         if (k == 1) first_fall_cyc = cyc;
         tick(HALF);
         dev_clk = 1'b1;
         tick(4);
         if (k <= 10) dev_bits[k-1] = ps2_dat_in;
         if (k == 11) dev_dat = 1'b1;
         if (k == glitch_at) begin
            tick(4);
            dev_clk = 1'b0;
            tick(2);
            dev_clk = 1'b1;
            tick(HALF);
         end else begin
            tick(HALF - 4);
         end
      end
   endtask

   task automatic wait_done();
      int g = 0;
      while (sb.size() != 0 && g < 3000) begin
         @(posedge CLOCK_50);
         g++;
      end
      #1;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL done_wait: %0d expected completions missing after %0d cycles", sb.size(), g);
         sb.delete();
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      int inh, rts, ff;
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      @(negedge CLOCK_50);
      check("rst_tx_ready", int'(tx_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_tx_done", int'(tx_done), 0);
      check("rst_tx_status", int'(tx_status), 0);
      check("rst_clk_oe", int'(ps2_clk_oe), 0);
      check("rst_dat_oe", int'(ps2_dat_oe), 0);
      tick(3);
      @(negedge CLOCK_50) reset = 1'b0;

      // 0xED: bits 1,0,1,1,0,1,1,1, odd parity 1, device ACKs
      sb.push_back('{2'b00, 1'b1, 8'hED, 1'b1, 0});
      send(8'hED);
      dev_run(11, 1'b1, 0, inh, rts, ff);
      check("inhibit_cycles", inh, 120);
      wait_done();
      check("ready_after_done", int'(tx_ready), 1);
      check("busy_after_done", int'(busy), 0);

      // 0x00: parity 1, device leaves data high on the 11th edge -> NACK
      sb.push_back('{2'b01, 1'b1, 8'h00, 1'b1, 0});
      send(8'h00);
      dev_run(11, 1'b0, 0, inh, rts, ff);
      wait_done();
      check("nack_clk_oe_after", int'(ps2_clk_oe), 0);
      check("nack_dat_oe_after", int'(ps2_dat_oe), 0);

      // Device never clocks: done 50 cycles after RTS entry
      send(8'h12);
      dev_run(0, 1'b1, 0, inh, rts, ff);
      sb.push_back('{2'b10, 1'b0, 8'h00, 1'b0, rts + START_US});
      wait_done();

      // Four edges then silence: fall_edge lags the pad by 2 + FILTER_LEN cycles, done XFER_US after that
      send(8'hA5);
      dev_run(4, 1'b1, 0, inh, rts, ff);
      sb.push_back('{2'b11, 1'b0, 8'h00, 1'b0, ff + 2 + FILTER_LEN + XFER_US});
      wait_done();

      // 0xE3 bit4 = 0, so data is driven low after edge 5 when reset hits
      send(8'hE3);
      dev_run(5, 1'b1, 0, inh, rts, ff);
      check("dat_oe_before_reset", int'(ps2_dat_oe), 1);
      reset = 1'b1;
      #1;
      check("async_rst_clk_oe", int'(ps2_clk_oe), 0);
      check("async_rst_dat_oe", int'(ps2_dat_oe), 0);
      check("async_rst_busy", int'(busy), 0);
      tick(3);
      @(negedge CLOCK_50) reset = 1'b0;
      @(negedge CLOCK_50);
      check("ready_after_reset", int'(tx_ready), 1);
      sb.push_back('{2'b00, 1'b1, 8'hFF, 1'b1, 0});
      send(8'hFF);
      dev_run(11, 1'b1, 0, inh, rts, ff);
      wait_done();

      // 0x5B (parity 0) with a 2-cycle clock glitch after edge 3 and a 0xEE request while busy
      sb.push_back('{2'b00, 1'b1, 8'h5B, 1'b0, 0});
      send(8'h5B);
      tx_data  = 8'hEE;
      tx_valid = 1'b1;
      tick(20);
      check("ready_while_busy", int'(tx_ready), 0);
      tx_valid = 1'b0;
      dev_run(11, 1'b1, 3, inh, rts, ff);
      wait_done();
      tick(300);
      check("idle_after_ignored", int'(busy), 0);
      check("no_new_inhibit", int'(ps2_clk_oe), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
